// File: rtl/acc_core_ctrl.sv
// Multicycle accumulator-machine controller and datapath for a 32x8 unified memory.
module acc_core_ctrl #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              c_flag,
  output logic              halted
);

  localparam int unsigned OP_W = DATA_W - ADDR_W;
  localparam int unsigned SUM_W = DATA_W + 1;

  localparam logic [OP_W-1:0] OP_LDA = OP_W'(0);
  localparam logic [OP_W-1:0] OP_STA = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(3);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(4);
  localparam logic [OP_W-1:0] OP_NOT = OP_W'(5);
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(6);
  localparam logic [OP_W-1:0] OP_JZ  = OP_W'(7);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              c_q, c_d;

  logic [OP_W-1:0]   op;
  logic [ADDR_W-1:0] opnd;
  logic [SUM_W-1:0]  sum;

  assign op   = ir_q[DATA_W-1:ADDR_W];
  assign opnd = ir_q[ADDR_W-1:0];
  assign sum  = SUM_W'(acc_q) + SUM_W'(mem_rdata);

  // State and architectural registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= ADDR_W'(RESET_PC);
      acc_q   <= '0;
      ir_q    <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
      c_q     <= c_d;
    end
  end

  // Next-state, datapath updates and memory port control.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    acc_d    = acc_q;
    ir_d     = ir_q;
    c_d      = c_q;
    mem_addr = pc_q;
    mem_we   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (run) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        mem_addr = opnd;
        case (op)
          OP_NOT: begin
            acc_d   = ~acc_q;
            state_d = S_FETCH;
          end
          OP_JMP: begin
            pc_d    = opnd;
            // A jump to its own address is the halt idiom.
            state_d = (opnd == pc_q - ADDR_W'(1)) ? S_HALT : S_FETCH;
          end
          OP_JZ: begin
            if (acc_q == '0) pc_d = opnd;
            state_d = S_FETCH;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        mem_addr = opnd;
        case (op)
          OP_LDA: acc_d = mem_rdata;
          OP_STA: mem_we = 1'b1;
          OP_ADD: begin
            acc_d = sum[DATA_W-1:0];
            c_d   = sum[DATA_W];
          end
          OP_SUB: begin
            acc_d = acc_q - mem_rdata;
            c_d   = (mem_rdata > acc_q);
          end
          OP_AND: acc_d = acc_q & mem_rdata;
          default: ;
        endcase
        state_d = S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  assign mem_wdata = acc_q;
  assign acc_out   = acc_q;
  assign pc_out    = pc_q;
  assign c_flag    = c_q;
  assign halted    = (state_q == S_HALT);

endmodule

// File: doc/acc_core_ctrl.md
Name: acc_core_ctrl

Overview:
Multicycle accumulator-machine controller and datapath that drives the 32x8 unified instruction/data memory. It fetches 8-bit instructions (opcode[7:5], operand address[4:0]), reads operands, and writes results back through the memory's combinational-read, posedge-write port. It sits directly upstream of the memory and is its only master.

Parameters:
ADDR_W, 5, memory address width; DATA_W must equal ADDR_W+3
DATA_W, 8, instruction and data word width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  fetch enable; sampled only in FETCH
mem_addr  output  ADDR_W  memory address (combinational from state)
mem_we  output  1  memory write enable (combinational from state)
mem_wdata  output  DATA_W  write data, always equals ACC
mem_rdata  input  DATA_W  combinational read data from memory
acc_out  output  DATA_W  accumulator
pc_out  output  ADDR_W  program counter
c_flag  output  1  carry/borrow flag
halted  output  1  high while in HALT

Behaviour:
- Reset (async, rst_n=0): state=FETCH, PC=RESET_PC, ACC=0, IR=0, C=0; halted=0; mem_we=0 immediately, including mid-STA.
- Opcodes: 000 LDA, 001 STA, 010 ADD, 011 SUB, 100 AND, 101 NOT, 110 JMP, 111 JZ. Operand A=IR[4:0].
- FSM states: FETCH, DECODE, EXEC, HALT.
- FETCH: mem_addr=PC, mem_we=0. If run=1: IR<=mem_rdata, PC<=PC+1 (wraps 31->0), go DECODE. If run=0: hold all state, stay FETCH.
- DECODE: mem_addr=A, mem_we=0.
  - LDA/STA/ADD/SUB/AND -> EXEC.
  - NOT: ACC<=~ACC; C unchanged; -> FETCH.
  - JMP: PC<=A. If A equals the instruction's own address (PC-1 mod 32) -> HALT, else -> FETCH.
  - JZ: if ACC==0, PC<=A; -> FETCH. Never halts, even when self-targeted.
- EXEC: mem_addr=A.
  - LDA: ACC<=mem_rdata.
  - ADD: {C,ACC}<=ACC+mem_rdata (9-bit sum).
  - SUB: ACC<=ACC-mem_rdata mod 256; C<=1 iff mem_rdata>ACC (borrow).
  - AND: ACC<=ACC&mem_rdata.
  - STA: mem_we=1, mem_wdata=ACC; the memory captures the write at this cycle's rising edge.
  - All cases -> FETCH. C is unchanged except by ADD and SUB.
- HALT: mem_addr=PC, mem_we=0, halted=1. The core stays in HALT until reset; run is ignored.
- Latency:
  - Memory-operand instructions take 3 cycles.
  - NOT, JMP and JZ take 2 cycles.
  - Stalled FETCH cycles add 1 cycle each.
- mem_we is high only in EXEC with opcode STA, and never in any other state.
- Self-modifying code is legal. A STA to the next PC is seen by the following FETCH, because the read is combinational and the write lands at the edge that ends EXEC.
- Outputs acc_out, pc_out, c_flag and halted are direct register/state views, with no extra latency.

Test Plan:
- Add-and-store: mem[0]=0x14 (LDA 20), mem[1]=0x55 (ADD 21), mem[2]=0x36 (STA 22), mem[3]=0xC3 (JMP 3), mem[20]=0x05, mem[21]=0x07, run=1, release reset -> mem_we pulses exactly once, at edge 9 with addr 22/data 0x0C; halted=1 after edge 11; pc_out=3, acc_out=0x0C, c_flag=0.
- Carry/borrow: ACC=0xF0, ADD of 0x20 -> ACC=0x10, C=1. Then SUB of 0x30 -> ACC=0xE0, C=1. Then SUB of 0x10 -> ACC=0xD0, C=0.
- Branching and NOT:
  - LDA of 0x00, then JZ 10 -> pc_out=10 after 2 cycles.
  - LDA of 0x01, then JZ 10 -> PC falls through.
  - NOT on 0x5A -> 0xA5, with C unchanged.
- Stall: hold run=0 for 4 cycles in FETCH -> PC, ACC and IR unchanged, mem_we=0, mem_addr=PC. Raise run -> execution resumes with identical results, only 4 cycles later.
- Wrap and async reset:
  - Instruction at address 31 -> PC becomes 0 after its FETCH.
  - Assert rst_n low mid-EXEC of STA (between edges) -> mem_we drops to 0 with no clock edge, the target word is unchanged, and all outputs return to their reset values.
